// File: rtl/regfile_seq_pkg.sv
// regfile_seq_pkg: shared command format, addresses and status states for the transfer sequencer
package regfile_seq_pkg;
    localparam logic [5:0] X0_ADDR      = 6'd0;
    localparam logic [5:0] DATA_IO_ADDR = 6'd32;
    localparam int         MASK_W       = 33;

    typedef struct packed {
        logic [5:0]        src;
        logic [MASK_W-1:0] dest;
    } rf_cmd_t;

    typedef enum logic [1:0] { IDLE, RUN, STALL_IN, STALL_OUT } seq_state_t;

    function automatic logic is_illegal(input logic [5:0] src);
        return src > DATA_IO_ADDR;
    endfunction
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: DEPTH-entry command queue; full refuses pushes even while popping
module cmd_fifo import regfile_seq_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    i_push,
    input  rf_cmd_t i_data,
    input  logic    i_pop,
    output logic    o_full,
    output logic    o_empty,
    output rf_cmd_t o_head
);
    localparam int AW = $clog2(DEPTH);

    rf_cmd_t         r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [AW:0]     r_cnt;
    logic            w_push;
    logic            w_pop;

    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: issues queued register-transfer commands one per cycle,
// bridging DATA_IO sources/destinations to valid/ready streams
module regfile_sequencer import regfile_seq_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [5:0]        cmd_src,
    input  logic [MASK_W-1:0] cmd_dest,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [5:0]        rf_src_addr,
    output logic [MASK_W-1:0] rf_dest_msk,
    output logic [31:0]       rf_data_in,
    input  logic [31:0]       rf_data_out,
    output logic              busy,
    output logic              err
);
    rf_cmd_t    w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_head_io;
    logic       w_in_ok;
    logic       w_out_ok;
    logic       w_issue;
    logic       r_out_valid;
    logic [31:0] r_out_data;
    logic       r_err;
    seq_state_t r_state;

    cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (cmd_valid),
        .i_data  ('{src: cmd_src, dest: cmd_dest}),
        .i_pop   (w_issue),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign w_head_io = w_head.src == DATA_IO_ADDR;
    assign w_in_ok   = !w_head_io || in_valid;
    assign w_out_ok  = !w_head.dest[MASK_W-1] || !r_out_valid || out_ready;
    assign w_issue   = !w_empty && w_in_ok && w_out_ok;

    // illegal sources are issued as x0 so every selected destination receives 0
    assign rf_src_addr = w_issue && !is_illegal(w_head.src) ? w_head.src : X0_ADDR;
    assign rf_dest_msk = w_issue ? w_head.dest : '0;
    assign rf_data_in  = w_issue ? in_data : '0;
    assign in_ready    = w_issue && w_head_io;
    assign cmd_ready   = !w_full;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign busy        = !w_empty || r_out_valid;
    assign err         = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_err       <= 1'b0;
            r_state     <= IDLE;
        end else begin
            if (w_issue && w_head.dest[MASK_W-1]) begin
                r_out_valid <= 1'b1;
                r_out_data  <= rf_data_out;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_issue && is_illegal(w_head.src)) r_err <= 1'b1;
            r_state <= w_empty ? IDLE : w_issue ? RUN : !w_in_ok ? STALL_IN : STALL_OUT;
        end
    end
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: directed checks of the sequencer against a small register-file model
module tb_regfile_sequencer;
    import regfile_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_src = '0;
    logic [32:0] cmd_dest = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [5:0]  rf_src_addr;
    logic [32:0] rf_dest_msk;
    logic [31:0] rf_data_in;
    logic [31:0] rf_data_out;
    logic        busy;
    logic        err;
    logic [31:0] regs [32];
    int          vectors = 0;
    int          miscompares = 0;

    localparam logic [32:0] IO = 33'h1_0000_0000;

    regfile_sequencer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dest(cmd_dest), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rf_src_addr(rf_src_addr), .rf_dest_msk(rf_dest_msk), .rf_data_in(rf_data_in),
        .rf_data_out(rf_data_out), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    assign rf_data_out = rf_src_addr == 6'd0 ? 32'd0 :
                         rf_src_addr == 6'd32 ? rf_data_in : regs[rf_src_addr[4:0]];

    always @(posedge clk or posedge reset) begin
        if (reset) for (int i = 0; i < 32; i++) regs[i] <= 32'h100 + i;
        else for (int i = 1; i < 32; i++) if (rf_dest_msk[i]) regs[i] <= rf_data_out;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_rf_src", 64'(rf_src_addr), 64'd0);
        chk("rst_rf_dest", 64'(rf_dest_msk), 64'd0);
        chk("rst_rf_data_in", 64'(rf_data_in), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();
        chk("idle_state", 64'(dut.r_state), 64'(IDLE));

        // DATA_IO source into x5, then x5 out to DATA_IO
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        cmd_valid = 1'b1; cmd_src = 6'd32; cmd_dest = 33'h20;
        tick();
        cmd_src = 6'd5; cmd_dest = IO;
        #1;
        chk("io_in_ready", 64'(in_ready), 64'd1);
        chk("io_rf_src", 64'(rf_src_addr), 64'd32);
        chk("io_rf_dest", 64'(rf_dest_msk), 64'h20);
        chk("io_rf_data_in", 64'(rf_data_in), 64'hDEADBEEF);
        tick();
        cmd_valid = 1'b0; in_valid = 1'b0;
        #1;
        chk("io_in_ready_pulse", 64'(in_ready), 64'd0);
        chk("io2_rf_src", 64'(rf_src_addr), 64'd5);
        chk("io2_rf_dest", 64'(rf_dest_msk), 64'(IO));
        chk("io_state_run", 64'(dut.r_state), 64'(RUN));
        tick();
        chk("io_out_valid", 64'(out_valid), 64'd1);
        chk("io_out_data", 64'(out_data), 64'hDEADBEEF);
        chk("io_busy", 64'(busy), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("io_drained", 64'(out_valid), 64'd0);
        chk("io_busy_clr", 64'(busy), 64'd0);

        // input stall for 3 cycles, then back-to-back dependent read of x7
        cmd_valid = 1'b1; cmd_src = 6'd32; cmd_dest = 33'h80;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stin_rf_dest", 64'(rf_dest_msk), 64'd0);
            chk("stin_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        chk("stin_state", 64'(dut.r_state), 64'(STALL_IN));
        in_valid = 1'b1; in_data = 32'h12345678;
        cmd_valid = 1'b1; cmd_src = 6'd7; cmd_dest = IO;
        #1;
        chk("stin_release_in_ready", 64'(in_ready), 64'd1);
        chk("stin_release_dest", 64'(rf_dest_msk), 64'h80);
        tick();
        cmd_valid = 1'b0; in_valid = 1'b0;
        #1;
        chk("dep_rf_src", 64'(rf_src_addr), 64'd7);
        chk("dep_rf_dest", 64'(rf_dest_msk), 64'(IO));
        tick();
        chk("dep_out_data", 64'(out_data), 64'h12345678);
        chk("dep_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // output backpressure: x3 then x4 to DATA_IO with out_ready low
        cmd_valid = 1'b1; cmd_src = 6'd3; cmd_dest = IO;
        tick();
        cmd_src = 6'd4;
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_out_data", 64'(out_data), 64'h103);
        chk("bp_stall_dest", 64'(rf_dest_msk), 64'd0);
        tick();
        chk("bp_state", 64'(dut.r_state), 64'(STALL_OUT));
        chk("bp_hold_data", 64'(out_data), 64'h103);
        out_ready = 1'b1;
        #1;
        chk("bp_issue_on_drain", 64'(rf_dest_msk), 64'(IO));
        tick();
        out_ready = 1'b0;
        chk("bp_refill_valid", 64'(out_valid), 64'd1);
        chk("bp_refill_data", 64'(out_data), 64'h104);
        tick();
        chk("bp_held_no_ready", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_empty", 64'(out_valid), 64'd0);

        // fill the FIFO behind an input stall
        cmd_valid = 1'b1; cmd_src = 6'd32; cmd_dest = 33'h200;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("full_ready_before", 64'(cmd_ready), 64'd1);
            tick();
        end
        chk("full_ready_low", 64'(cmd_ready), 64'd0);
        chk("full_busy", 64'(busy), 64'd1);
        cmd_src = 6'd1; cmd_dest = 33'h400;
        in_valid = 1'b1; in_data = 32'hA5A5_0001;
        #1;
        chk("full_pop_cycle_ready", 64'(cmd_ready), 64'd0);
        chk("full_pop_in_ready", 64'(in_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("full_drain_dest", 64'(rf_dest_msk), 64'h200);
            tick();
        end
        #1;
        chk("full_refused_dest", 64'(rf_dest_msk), 64'd0);
        chk("full_refused_busy", 64'(busy), 64'd0);
        in_valid = 1'b0;
        tick();
        chk("full_idle", 64'(dut.r_state), 64'(IDLE));

        // illegal source, then reset mid-stream
        cmd_valid = 1'b1; cmd_src = 6'd40; cmd_dest = IO | 33'h8;
        tick();
        cmd_src = 6'd32; cmd_dest = IO;
        #1;
        chk("ill_rf_src", 64'(rf_src_addr), 64'd0);
        chk("ill_rf_dest", 64'(rf_dest_msk), 64'(IO | 33'h8));
        tick();
        cmd_valid = 1'b0;
        chk("ill_err", 64'(err), 64'd1);
        chk("ill_out_valid", 64'(out_valid), 64'd1);
        chk("ill_out_data", 64'(out_data), 64'd0);
        chk("ill_x3_zero", 64'(regs[3]), 64'd0);
        tick();
        chk("ill_err_sticky", 64'(err), 64'd1);
        chk("both_stall_state", 64'(dut.r_state), 64'(STALL_IN));
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_err", 64'(err), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        #1 reset = 1'b0;
        tick();
        in_valid = 1'b1;
        #1;
        chk("flushed_dest", 64'(rf_dest_msk), 64'd0);
        chk("flushed_in_ready", 64'(in_ready), 64'd0);
        chk("flushed_state", 64'(dut.r_state), 64'(IDLE));
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
